// File: rtl/axi_stream_protocol_checker_pkg.sv
// Shared constants and helpers for the AXI-Stream protocol checker.
// Rule indices double as the error code reported on first_err_code.
package axis_chk_pkg;

    localparam int ERR_W      = 6;
    localparam int ERR_CODE_W = 3;

    localparam int RULE_VALID_DROP       = 0;
    localparam int RULE_PAYLOAD_UNSTABLE = 1;
    localparam int RULE_STRB_NO_KEEP     = 2;
    localparam int RULE_VALID_EARLY      = 3;
    localparam int RULE_STALL_TIMEOUT    = 4;
    localparam int RULE_INTERLEAVE       = 5;

    typedef enum logic [ERR_CODE_W-1:0] {
        CODE_VALID_DROP       = 3'd0,
        CODE_PAYLOAD_UNSTABLE = 3'd1,
        CODE_STRB_NO_KEEP     = 3'd2,
        CODE_VALID_EARLY      = 3'd3,
        CODE_STALL_TIMEOUT    = 3'd4,
        CODE_INTERLEAVE       = 3'd5
    } errCode_e;

    // Lowest-numbered rule among those firing in one cycle.
    function automatic errCode_e lowestRule(input logic [ERR_W-1:0] hits);
        errCode_e code;
        code = CODE_VALID_DROP;
        for (int i = ERR_W - 1; i >= 0; i--) begin
            if (hits[i]) begin
                code = errCode_e'(i[ERR_CODE_W-1:0]);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/axi_stream_protocol_checker_if.sv
// AXI-Stream bus bundle. The checker only observes, so it uses the
// monitor modport; master/slave describe the real endpoints.
interface axi_stream_protocol_checker_if #(
    parameter int BYTE_WIDTH = 4,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);

    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [8*BYTE_WIDTH-1:0] tdata;
    logic [BYTE_WIDTH-1:0]   tstrb;
    logic [BYTE_WIDTH-1:0]   tkeep;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tlast, tdata, tstrb, tkeep, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tlast, tdata, tstrb, tkeep, tid, tdest, tuser,
        output tready
    );

    modport monitor (
        input tvalid, tready, tlast, tdata, tstrb, tkeep, tid, tdest, tuser
    );

endinterface

// File: rtl/axi_stream_protocol_checker_stall_timer.sv
// Counts consecutive stall cycles (valid without ready) and emits a single
// pulse in the cycle the count reaches STALL_TIMEOUT. The count parks at the
// limit so a long stall reports only once; any non-stall cycle rearms it.
// STALL_TIMEOUT = 0 disables the pulse entirely.
module axis_chk_stall_timer #(
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_i,
    output logic timeout_o
);

    localparam int            CW    = (STALL_TIMEOUT < 1) ? 1 : $clog2(STALL_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count and the one-cycle timeout pulse.
    always_comb begin
        count_d   = count_q;
        timeout_o = 1'b0;
        if (!stall_i) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d   = count_q + CW'(1);
            timeout_o = (STALL_TIMEOUT != 0) && (count_d == LIMIT);
        end
    end

    // Stall count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi_stream_protocol_checker.sv
// Passive AXI-Stream protocol checker: sticky per-rule error flags, the first
// rule violated, and saturating beat/packet counters.
// Optional feature: define AXIS_CHK_INTERLEAVE_EN to compile in the
// tid/tdest interleave rule (rule 5); otherwise err_flags[5] stays 0.
module axi_stream_protocol_checker
    import axis_chk_pkg::*;
#(
    parameter int BYTE_WIDTH    = 4,
    parameter int ID_WIDTH      = 1,
    parameter int DEST_WIDTH    = 1,
    parameter int USER_WIDTH    = 1,
    parameter int CNT_WIDTH     = 32,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    axi_stream_protocol_checker_if.monitor bus,
    input  logic                          err_clear,
    input  logic                          stats_clear,
    output logic [ERR_W-1:0]              err_flags,
    output logic                          err_any,
    output logic                          first_err_valid,
    output logic [ERR_CODE_W-1:0]         first_err_code,
    output logic [CNT_WIDTH-1:0]          beat_count,
    output logic [CNT_WIDTH-1:0]          pkt_count
);

    localparam int PAYLOAD_W = 8*BYTE_WIDTH + 2*BYTE_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    logic                 handshake;
    logic                 stall;
    logic                 prevStall;
    logic                 stallTimeout;
    logic                 interleaveHit;
    logic [PAYLOAD_W-1:0] payload;
    logic [ERR_W-1:0]     viol;

    // Previous-cycle samples; historyValid_q is low only in the first cycle
    // after reset, where history-based rules have nothing to compare against.
    logic                 historyValid_q;
    logic                 prevValid_q;
    logic                 prevReady_q;
    logic [PAYLOAD_W-1:0] prevPayload_q;

    logic [ERR_W-1:0]     flags_q, flags_d;
    logic                 firstValid_q, firstValid_d;
    errCode_e             firstCode_q, firstCode_d;
    logic [CNT_WIDTH-1:0] beatCount_q, beatCount_d;
    logic [CNT_WIDTH-1:0] pktCount_q, pktCount_d;

    assign handshake = bus.tvalid & bus.tready;
    assign stall     = bus.tvalid & ~bus.tready;
    assign prevStall = prevValid_q & ~prevReady_q;
    assign payload   = {bus.tdata, bus.tstrb, bus.tkeep, bus.tlast, bus.tid, bus.tdest, bus.tuser};

    axis_chk_stall_timer #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) stallTimer (
        .clk       (clk),
        .reset     (reset),
        .stall_i   (stall),
        .timeout_o (stallTimeout)
    );

`ifdef AXIS_CHK_INTERLEAVE_EN
    logic                  pktOpen_q;
    logic [ID_WIDTH-1:0]   lastId_q;
    logic [DEST_WIDTH-1:0] lastDest_q;

    assign interleaveHit = historyValid_q & handshake & pktOpen_q &
                           ((bus.tid != lastId_q) | (bus.tdest != lastDest_q));

    // Open-packet state and routing of the last accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            pktOpen_q  <= 1'b0;
            lastId_q   <= '0;
            lastDest_q <= '0;
        end else if (handshake) begin
            pktOpen_q  <= ~bus.tlast;
            lastId_q   <= bus.tid;
            lastDest_q <= bus.tdest;
        end
    end
`else
    assign interleaveHit = 1'b0;
`endif

    // Rule evaluation for the current cycle.
    always_comb begin
        viol                        = '0;
        viol[RULE_VALID_DROP]       = historyValid_q & prevStall & ~bus.tvalid;
        viol[RULE_PAYLOAD_UNSTABLE] = historyValid_q & prevStall & bus.tvalid & (payload != prevPayload_q);
        viol[RULE_STRB_NO_KEEP]     = bus.tvalid & (|(bus.tstrb & ~bus.tkeep));
        viol[RULE_VALID_EARLY]      = bus.tvalid & ~historyValid_q;
        viol[RULE_STALL_TIMEOUT]    = historyValid_q & stallTimeout;
        viol[RULE_INTERLEAVE]       = interleaveHit;
    end

    // Sticky flags and first-error capture; a clear is applied before this
    // cycle's violations so a simultaneous violation survives the clear.
    always_comb begin
        flags_d      = err_clear ? '0 : flags_q;
        firstValid_d = err_clear ? 1'b0 : firstValid_q;
        firstCode_d  = err_clear ? CODE_VALID_DROP : firstCode_q;
        flags_d      = flags_d | viol;
        if (!firstValid_d && (|viol)) begin
            firstValid_d = 1'b1;
            firstCode_d  = lowestRule(viol);
        end
    end

    // Saturating beat and packet counters; stats_clear beats a handshake.
    always_comb begin
        beatCount_d = beatCount_q;
        pktCount_d  = pktCount_q;
        if (stats_clear) begin
            beatCount_d = '0;
            pktCount_d  = '0;
        end else if (handshake) begin
            if (beatCount_q != '1) begin
                beatCount_d = beatCount_q + CNT_WIDTH'(1);
            end
            if (bus.tlast && (pktCount_q != '1)) begin
                pktCount_d = pktCount_q + CNT_WIDTH'(1);
            end
        end
    end

    // Capture last cycle's handshake state and payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            historyValid_q <= 1'b0;
            prevValid_q    <= 1'b0;
            prevReady_q    <= 1'b0;
            prevPayload_q  <= '0;
        end else begin
            historyValid_q <= 1'b1;
            prevValid_q    <= bus.tvalid;
            prevReady_q    <= bus.tready;
            prevPayload_q  <= payload;
        end
    end

    // Error and statistics state.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q      <= '0;
            firstValid_q <= 1'b0;
            firstCode_q  <= CODE_VALID_DROP;
            beatCount_q  <= '0;
            pktCount_q   <= '0;
        end else begin
            flags_q      <= flags_d;
            firstValid_q <= firstValid_d;
            firstCode_q  <= firstCode_d;
            beatCount_q  <= beatCount_d;
            pktCount_q   <= pktCount_d;
        end
    end

    assign err_flags       = flags_q;
    assign err_any         = |flags_q;
    assign first_err_valid = firstValid_q;
    assign first_err_code  = firstCode_q;
    assign beat_count      = beatCount_q;
    assign pkt_count       = pktCount_q;

endmodule

// File: tb/tb_axi_stream_protocol_checker.sv
// Self-checking bench for axi_stream_protocol_checker. Expected flag states
// are pushed to a scoreboard queue as each cycle's stimulus is driven and
// popped once the DUT has registered that cycle. Rule 5 expectations follow
// AXIS_CHK_INTERLEAVE_EN.
module tb_axi_stream_protocol_checker;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] ECLR = 3'b001;
    localparam logic [2:0] SCLR = 3'b010;
    localparam logic [2:0] RST  = 3'b100;

`ifdef AXIS_CHK_INTERLEAVE_EN
    localparam logic [5:0] IL_FLAGS = 6'b100000;
    localparam logic       IL_FV    = 1'b1;
    localparam logic [2:0] IL_CODE  = 3'd5;
`else
    localparam logic [5:0] IL_FLAGS = 6'b000000;
    localparam logic       IL_FV    = 1'b0;
    localparam logic [2:0] IL_CODE  = 3'd0;
`endif

    typedef struct packed {
        logic        v;
        logic        r;
        logic        last;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [1:0]  id;
        logic [2:0]  ctl;
    } stimT;

    typedef struct packed {
        logic [5:0] flags;
        logic       fv;
        logic [2:0] code;
    } expT;

    typedef struct packed {
        logic [CNT_W-1:0] beat;
        logic [CNT_W-1:0] pkt;
    } cntT;

    logic             clk;
    logic             reset;
    logic             errClear;
    logic             statsClear;
    logic [5:0]       errFlags;
    logic             errAny;
    logic             firstErrValid;
    logic [2:0]       firstErrCode;
    logic [CNT_W-1:0] beatCount;
    logic [CNT_W-1:0] pktCount;

    int  checks = 0;
    int  errors = 0;
    expT expQ[$];
    cntT cntQ[$];

    axi_stream_protocol_checker_if #(
        .BYTE_WIDTH(4), .ID_WIDTH(2), .DEST_WIDTH(1), .USER_WIDTH(1)
    ) axis ();

    axi_stream_protocol_checker #(
        .BYTE_WIDTH(4), .ID_WIDTH(2), .DEST_WIDTH(1), .USER_WIDTH(1),
        .CNT_WIDTH(CNT_W), .STALL_TIMEOUT(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (axis),
        .err_clear       (errClear),
        .stats_clear     (statsClear),
        .err_flags       (errFlags),
        .err_any         (errAny),
        .first_err_valid (firstErrValid),
        .first_err_code  (firstErrCode),
        .beat_count      (beatCount),
        .pkt_count       (pktCount)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case anything stalls the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stimT S(input logic v, input logic r, input logic last,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [3:0] keep, input logic [1:0] id,
                               input logic [2:0] ctl);
        stimT s;
        s.v = v; s.r = r; s.last = last; s.data = data;
        s.strb = strb; s.keep = keep; s.id = id; s.ctl = ctl;
        return s;
    endfunction

    function automatic expT E(input logic [5:0] flags, input logic fv, input logic [2:0] code);
        expT e;
        e.flags = flags; e.fv = fv; e.code = code;
        return e;
    endfunction

    task automatic applyStimulus(input stimT s);
        reset       = s.ctl[2];
        statsClear  = s.ctl[1];
        errClear    = s.ctl[0];
        axis.tvalid = s.v;
        axis.tready = s.r;
        axis.tlast  = s.last;
        axis.tdata  = s.data;
        axis.tstrb  = s.strb;
        axis.tkeep  = s.keep;
        axis.tid    = s.id;
        axis.tdest  = 1'b0;
        axis.tuser  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles, then one idle cycle so history is valid afterwards.
    task automatic doReset();
        applyStimulus(S(0, 0, 0, 32'h0, 4'hF, 4'hF, 2'd0, RST));
        tick();
        tick();
        applyStimulus(S(0, 0, 0, 32'h0, 4'hF, 4'hF, 2'd0, NONE));
        tick();
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (errFlags !== 6'b0 || errAny !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: flags=%b any=%b, expected 000000/0", errFlags, errAny);
        end
        checks++;
        if (firstErrValid !== 1'b0 || firstErrCode !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_first: valid=%b code=%0d, expected 0/0", firstErrValid, firstErrCode);
        end
        checks++;
        if (beatCount !== '0 || pktCount !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counts: beat=%0d pkt=%0d, expected 0/0", beatCount, pktCount);
        end
    endtask

    task automatic test_valid_drop();
        stimT st[$];
        expT  ex[$];
        expT  e;
        doReset();
        st.push_back(S(1, 1, 0, 32'h11, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(0, 0, 0, 32'h00, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 0, 0, 32'h22, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(0, 0, 0, 32'h00, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000001, 1, 0));
        st.push_back(S(0, 0, 0, 32'h00, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000001, 1, 0));
        for (int i = 0; i < st.size(); i++) begin
            applyStimulus(st[i]);
            expQ.push_back(ex[i]);
            tick();
            e = expQ.pop_front();
            checks++;
            if (errFlags !== e.flags || errAny !== (|e.flags) || firstErrValid !== e.fv || firstErrCode !== e.code) begin
                errors++;
                $display("[TB] FAIL valid_drop[%0d]: flags=%b any=%b fv=%b code=%0d, expected flags=%b fv=%b code=%0d",
                         i, errFlags, errAny, firstErrValid, firstErrCode, e.flags, e.fv, e.code);
            end
        end
    endtask

    task automatic test_payload_strb();
        stimT st[$];
        expT  ex[$];
        expT  e;
        doReset();
        st.push_back(S(1, 0, 0, 32'hAA, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 0, 0, 32'hBB, 4'hF, 4'h3, 0, NONE)); ex.push_back(E(6'b000110, 1, 1));
        st.push_back(S(1, 1, 0, 32'hBB, 4'hF, 4'h3, 0, NONE)); ex.push_back(E(6'b000110, 1, 1));
        st.push_back(S(0, 0, 0, 32'h00, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000110, 1, 1));
        for (int i = 0; i < st.size(); i++) begin
            applyStimulus(st[i]);
            expQ.push_back(ex[i]);
            tick();
            e = expQ.pop_front();
            checks++;
            if (errFlags !== e.flags || errAny !== (|e.flags) || firstErrValid !== e.fv || firstErrCode !== e.code) begin
                errors++;
                $display("[TB] FAIL payload_strb[%0d]: flags=%b any=%b fv=%b code=%0d, expected flags=%b fv=%b code=%0d",
                         i, errFlags, errAny, firstErrValid, firstErrCode, e.flags, e.fv, e.code);
            end
        end
    endtask

    task automatic test_valid_early();
        stimT st[$];
        expT  ex[$];
        expT  e;
        st.push_back(S(1, 0, 0, 32'h55, 4'hF, 4'hF, 0, RST));  ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 0, 0, 32'h55, 4'hF, 4'h3, 0, RST));  ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 0, 0, 32'h66, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b001000, 1, 3));
        st.push_back(S(1, 1, 0, 32'h66, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b001000, 1, 3));
        st.push_back(S(0, 0, 0, 32'h00, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b001000, 1, 3));
        for (int i = 0; i < st.size(); i++) begin
            applyStimulus(st[i]);
            expQ.push_back(ex[i]);
            tick();
            e = expQ.pop_front();
            checks++;
            if (errFlags !== e.flags || errAny !== (|e.flags) || firstErrValid !== e.fv || firstErrCode !== e.code) begin
                errors++;
                $display("[TB] FAIL valid_early[%0d]: flags=%b any=%b fv=%b code=%0d, expected flags=%b fv=%b code=%0d",
                         i, errFlags, errAny, firstErrValid, firstErrCode, e.flags, e.fv, e.code);
            end
        end
    endtask

    task automatic test_stall_timeout();
        stimT st[$];
        expT  ex[$];
        expT  e;
        doReset();
        for (int c = 1; c <= 10; c++) begin
            st.push_back(S(1, 0, 0, 32'h77, 4'hF, 4'hF, 0, NONE));
            ex.push_back((c < 4) ? E(6'b000000, 0, 0) : E(6'b010000, 1, 4));
        end
        st.push_back(S(1, 0, 0, 32'h77, 4'hF, 4'hF, 0, ECLR)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 0, 0, 32'h77, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 1, 0, 32'h77, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000000, 0, 0));
        for (int c = 1; c <= 4; c++) begin
            st.push_back(S(1, 0, 0, 32'h78, 4'hF, 4'hF, 0, NONE));
            ex.push_back((c < 4) ? E(6'b000000, 0, 0) : E(6'b010000, 1, 4));
        end
        for (int i = 0; i < st.size(); i++) begin
            applyStimulus(st[i]);
            expQ.push_back(ex[i]);
            tick();
            e = expQ.pop_front();
            checks++;
            if (errFlags !== e.flags || errAny !== (|e.flags) || firstErrValid !== e.fv || firstErrCode !== e.code) begin
                errors++;
                $display("[TB] FAIL stall_timeout[%0d]: flags=%b any=%b fv=%b code=%0d, expected flags=%b fv=%b code=%0d",
                         i, errFlags, errAny, firstErrValid, firstErrCode, e.flags, e.fv, e.code);
            end
        end
    endtask

    task automatic test_interleave();
        stimT st[$];
        expT  ex[$];
        expT  e;
        doReset();
        st.push_back(S(1, 1, 0, 32'h01, 4'hF, 4'hF, 1, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 1, 1, 32'h02, 4'hF, 4'hF, 2, NONE)); ex.push_back(E(IL_FLAGS, IL_FV, IL_CODE));
        st.push_back(S(0, 0, 0, 32'h00, 4'hF, 4'hF, 0, ECLR)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 1, 0, 32'h03, 4'hF, 4'hF, 3, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 1, 1, 32'h04, 4'hF, 4'hF, 3, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 1, 1, 32'h05, 4'hF, 4'hF, 1, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 1, 0, 32'h06, 4'hF, 4'hF, 1, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(0, 0, 0, 32'h00, 4'hF, 4'hF, 0, RST));  ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(0, 0, 0, 32'h00, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(1, 1, 1, 32'h07, 4'hF, 4'hF, 2, NONE)); ex.push_back(E(6'b000000, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            applyStimulus(st[i]);
            expQ.push_back(ex[i]);
            tick();
            e = expQ.pop_front();
            checks++;
            if (errFlags !== e.flags || errAny !== (|e.flags) || firstErrValid !== e.fv || firstErrCode !== e.code) begin
                errors++;
                $display("[TB] FAIL interleave[%0d]: flags=%b any=%b fv=%b code=%0d, expected flags=%b fv=%b code=%0d",
                         i, errFlags, errAny, firstErrValid, firstErrCode, e.flags, e.fv, e.code);
            end
        end
    endtask

    task automatic test_err_clear();
        stimT st[$];
        expT  ex[$];
        expT  e;
        doReset();
        st.push_back(S(1, 0, 0, 32'h01, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000000, 0, 0));
        st.push_back(S(0, 0, 0, 32'h00, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000001, 1, 0));
        st.push_back(S(1, 1, 1, 32'h02, 4'hF, 4'h3, 0, ECLR)); ex.push_back(E(6'b000100, 1, 2));
        st.push_back(S(0, 0, 0, 32'h00, 4'hF, 4'hF, 0, NONE)); ex.push_back(E(6'b000100, 1, 2));
        st.push_back(S(1, 0, 0, 32'h03, 4'hF, 4'h3, 0, RST));  ex.push_back(E(6'b000000, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            applyStimulus(st[i]);
            expQ.push_back(ex[i]);
            tick();
            e = expQ.pop_front();
            checks++;
            if (errFlags !== e.flags || errAny !== (|e.flags) || firstErrValid !== e.fv || firstErrCode !== e.code) begin
                errors++;
                $display("[TB] FAIL err_clear[%0d]: flags=%b any=%b fv=%b code=%0d, expected flags=%b fv=%b code=%0d",
                         i, errFlags, errAny, firstErrValid, firstErrCode, e.flags, e.fv, e.code);
            end
        end
        checks++;
        if (beatCount !== '0 || pktCount !== '0) begin
            errors++;
            $display("[TB] FAIL err_clear_reset_counts: beat=%0d pkt=%0d, expected 0/0", beatCount, pktCount);
        end
    endtask

    task automatic test_counters();
        stimT st[$];
        int   modelBeat;
        int   modelPkt;
        cntT  c;
        doReset();
        for (int i = 0; i < 12; i++) begin
            st.push_back(S(1, 1, (i % 4) == 3, i, 4'hF, 4'hF, 0, NONE));
        end
        st.push_back(S(1, 0, 0, 32'h30, 4'hF, 4'hF, 0, NONE));
        st.push_back(S(0, 1, 1, 32'h31, 4'hF, 4'hF, 0, NONE));
        st.push_back(S(1, 1, 1, 32'h32, 4'hF, 4'hF, 0, SCLR));
        for (int i = 0; i < 20; i++) begin
            st.push_back(S(1, 1, 1, 32'h40 + i, 4'hF, 4'hF, 0, NONE));
        end
        modelBeat = 0;
        modelPkt  = 0;
        for (int i = 0; i < st.size(); i++) begin
            applyStimulus(st[i]);
            if (st[i].ctl[1]) begin
                modelBeat = 0;
                modelPkt  = 0;
            end else if (st[i].v && st[i].r) begin
                if (modelBeat < CNT_MAX) modelBeat++;
                if (st[i].last && modelPkt < CNT_MAX) modelPkt++;
            end
            c.beat = modelBeat[CNT_W-1:0];
            c.pkt  = modelPkt[CNT_W-1:0];
            cntQ.push_back(c);
            tick();
            c = cntQ.pop_front();
            checks++;
            if (beatCount !== c.beat || pktCount !== c.pkt) begin
                errors++;
                $display("[TB] FAIL counters[%0d]: beat=%0d pkt=%0d, expected beat=%0d pkt=%0d",
                         i, beatCount, pktCount, c.beat, c.pkt);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        applyStimulus(S(0, 0, 0, 32'h0, 4'hF, 4'hF, 0, RST));
        test_reset();
        test_valid_drop();
        test_payload_strb();
        test_valid_early();
        test_stall_timeout();
        test_interleave();
        test_err_clear();
        test_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_stream_protocol_checker.md
AXI_STREAM_PROTOCOL_CHECKER -- requirements
Module: axi_stream_protocol_checker

Interface
REQ-001 SHALL have parameter BYTE_WIDTH, 4, TDATA bytes (>=1).
REQ-002 SHALL have parameter ID_WIDTH, 1, TID bits (>=1).
REQ-003 SHALL have parameter DEST_WIDTH, 1, TDEST bits (>=1).
REQ-004 SHALL have parameter USER_WIDTH, 1, TUSER bits (>=1).
REQ-005 SHALL have parameter CNT_WIDTH, 32, beat/packet counter bits.
REQ-006 SHALL have parameter STALL_TIMEOUT, 1024, max consecutive TVALID&&!TREADY cycles; 0 disables the rule.
REQ-007 SHALL have ports: clk input 1 clock; reset input 1 synchronous active-high reset.
REQ-008 SHALL have monitored inputs: tvalid, tready, tlast 1 each; tdata 8*BYTE_WIDTH; tstrb, tkeep BYTE_WIDTH; tid ID_WIDTH; tdest DEST_WIDTH; tuser USER_WIDTH.
REQ-009 SHALL have inputs err_clear 1 (clear sticky errors) and stats_clear 1 (clear counters).
REQ-010 SHALL have outputs err_flags output 6 sticky per-rule flags; err_any output 1 OR of err_flags.
REQ-011 SHALL have outputs first_err_valid output 1 and first_err_code output 3 (first rule violated).
REQ-012 SHALL have outputs beat_count, pkt_count output CNT_WIDTH each.

Function
REQ-013 SHALL evaluate rules in cycle N from current inputs plus one-cycle-registered samples; flags visible cycle N+1.
REQ-014 Rule 0 VALID_DROP SHALL fire when tvalid falls and previous cycle was not tvalid&&tready.
REQ-015 Rule 1 PAYLOAD_UNSTABLE SHALL fire when previous cycle was tvalid&&!tready and any of tdata,tstrb,tkeep,tlast,tid,tdest,tuser differ.
REQ-016 Rule 2 STRB_NO_KEEP SHALL fire when tvalid and (tstrb & ~tkeep) != 0.
REQ-017 Rule 3 VALID_EARLY SHALL fire when tvalid is high in the first cycle after reset deasserts.
REQ-018 Rule 4 STALL_TIMEOUT SHALL fire once when the consecutive stall count reaches STALL_TIMEOUT; count clears on handshake or !tvalid.
REQ-019 Rule 5 INTERLEAVE SHALL fire on a handshake whose tid or tdest differs from the previous handshake of an open packet (no tlast yet).
REQ-020 Packet-open state SHALL set on handshake with !tlast, clear on handshake with tlast.
REQ-021 Rules 0,1,4,5 SHALL be suppressed in the first cycle after reset (no valid history).
REQ-022 first_err_code SHALL latch the lowest-numbered rule firing while first_err_valid=0; held until err_clear.
REQ-023 err_clear SHALL zero flags and first_err_*; a violation in the same cycle SHALL win (set after clear).
REQ-024 beat_count SHALL increment on tvalid&&tready; pkt_count on tvalid&&tready&&tlast; both saturate at all-ones.
REQ-025 stats_clear in the same cycle as a handshake SHALL yield count 0 (clear wins).

Reset
REQ-026 reset SHALL zero err_flags, err_any, first_err_*, beat_count, pkt_count, stall count, packet-open state and sampled history.
REQ-027 No rule SHALL fire while reset is high; reset mid-packet SHALL discard open-packet state.

Configuration
REQ-028 Macro AXIS_CHK_INTERLEAVE_EN defined: rule 5 and tid/tdest tracking compiled in.
REQ-029 Macro absent: rule 5 logic omitted, err_flags[5] tied 0, code 5 never reported.

Structure
REQ-030 Package axis_chk_pkg SHALL hold rule-index constants 0..5, ERR_W=6, ERR_CODE_W=3.
REQ-031 Sub-module axis_chk_stall_timer SHALL implement the stall counter and single-shot timeout pulse.

Verification
REQ-032 tvalid=1,tready=0 cycle 5, tvalid=0 cycle 6 -> err_flags=6'b000001, first_err_code=0 at cycle 7.
REQ-033 stall with tdata 0xAA->0xBB and tstrb=4'hF,tkeep=4'h3 same cycle -> flags bits1,2 set, first_err_code=1.
REQ-034 STALL_TIMEOUT=4, tvalid=1,tready=0 for 10 cycles -> bit4 set after 4th stall cycle, single pulse; no rule 0/1.
REQ-035 macro defined, beats tid=1 !tlast then tid=2 -> bit5 set; macro absent -> err_flags=0.
REQ-036 3 packets of 4 beats -> beat_count=12, pkt_count=3; stats_clear with handshake -> 0; CNT_WIDTH=4, 20 beats -> 15.
REQ-037 err_clear with concurrent rule 2 violation -> bit2 remains, first_err_code=2; reset high 1 cycle -> all outputs 0.
